// File: rtl/round_controller.sv
// Round/score sequencer: tracks level and lives from the registered win/lose
// flags, holds result banners, and issues the frog-respawn pulse.
module round_controller #(
  parameter int LIVES       = 3,
  parameter int WIN_LEVELS  = 7,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       winResult,
  input  logic       loseResult,
  output logic       frogReset,
  output logic       freeze,
  output logic       showWin,
  output logic       showLose,
  output logic       gameOver,
  output logic       gameWon,
  output logic [3:0] level,
  output logic [2:0] lives,
  output logic [2:0] dbg_state
);

  localparam int               HW         = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]    HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [3:0]       LEVEL_MAX  = 4'(WIN_LEVELS);
  localparam logic [2:0]       LIVES_INIT = 3'(LIVES);
  localparam logic [1:0]       GUARD_LOAD = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_WIN_HOLD  = 3'd2,
    S_LOSE_HOLD = 3'd3,
    S_OVER      = 3'd4,
    S_WON       = 3'd5
  } state_t;

  state_t          r_state;
  logic            r_start_q;
  logic [1:0]      r_guard;
  logic [HW-1:0]   r_hold;
  logic [3:0]      r_level;
  logic [2:0]      r_lives;
  logic            r_frog_reset, r_freeze, r_show_win, r_show_lose, r_game_over, r_game_won;

  state_t          w_next_state;
  logic [1:0]      w_guard_n;
  logic [HW-1:0]   w_hold_n;
  logic [3:0]      w_level_n;
  logic [2:0]      w_lives_n;
  logic            w_frog_reset_n, w_freeze_n, w_show_win_n, w_show_lose_n;
  logic            w_game_over_n, w_game_won_n;
  logic            w_start_rise;
  logic [3:0]      w_level_inc;
  logic [2:0]      w_lives_dec;

  assign w_start_rise = start & ~r_start_q;
  // Saturating step values; they never wrap past the limits.
  assign w_level_inc  = (r_level < LEVEL_MAX) ? r_level + 4'd1 : r_level;
  assign w_lives_dec  = (r_lives != 3'd0) ? r_lives - 3'd1 : 3'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_start_q    <= 1'b0;
      r_guard      <= 2'd0;
      r_hold       <= '0;
      r_level      <= 4'd0;
      r_lives      <= LIVES_INIT;
      r_frog_reset <= 1'b0;
      r_freeze     <= 1'b1;
      r_show_win   <= 1'b0;
      r_show_lose  <= 1'b0;
      r_game_over  <= 1'b0;
      r_game_won   <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_start_q    <= start;
      r_guard      <= w_guard_n;
      r_hold       <= w_hold_n;
      r_level      <= w_level_n;
      r_lives      <= w_lives_n;
      r_frog_reset <= w_frog_reset_n;
      r_freeze     <= w_freeze_n;
      r_show_win   <= w_show_win_n;
      r_show_lose  <= w_show_lose_n;
      r_game_over  <= w_game_over_n;
      r_game_won   <= w_game_won_n;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_guard_n    = r_guard;
    w_hold_n     = r_hold;
    w_level_n    = r_level;
    w_lives_n    = r_lives;
    case (r_state)
      S_IDLE, S_OVER, S_WON: begin
        if (w_start_rise) begin
          w_next_state = S_PLAY;
          w_level_n    = 4'd0;
          w_lives_n    = LIVES_INIT;
          w_guard_n    = GUARD_LOAD;
        end
      end
      S_PLAY: begin
        // Guard masks results still in flight from before the respawn.
        if (r_guard != 2'd0) begin
          w_guard_n = r_guard - 2'd1;
        end else if (loseResult) begin
          w_lives_n    = w_lives_dec;
          w_hold_n     = HOLD_LOAD;
          w_next_state = (w_lives_dec == 3'd0) ? S_OVER : S_LOSE_HOLD;
        end else if (winResult) begin
          w_level_n    = w_level_inc;
          w_hold_n     = HOLD_LOAD;
          w_next_state = (w_level_inc == LEVEL_MAX) ? S_WON : S_WIN_HOLD;
        end
      end
      S_WIN_HOLD, S_LOSE_HOLD: begin
        if (r_hold == '0) begin
          w_next_state = S_PLAY;
          w_guard_n    = GUARD_LOAD;
        end else begin
          w_hold_n = r_hold - 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_frog_reset_n = (w_next_state == S_PLAY) && (r_state != S_PLAY);
    w_freeze_n     = (w_next_state != S_PLAY);
    w_show_win_n   = (w_next_state == S_WIN_HOLD) || (w_next_state == S_WON);
    w_show_lose_n  = (w_next_state == S_LOSE_HOLD) || (w_next_state == S_OVER);
    w_game_over_n  = (w_next_state == S_OVER);
    w_game_won_n   = (w_next_state == S_WON);
  end

  assign frogReset = r_frog_reset;
  assign freeze    = r_freeze;
  assign showWin   = r_show_win;
  assign showLose  = r_show_lose;
  assign gameOver  = r_game_over;
  assign gameWon   = r_game_won;
  assign level     = r_level;
  assign lives     = r_lives;
  assign dbg_state = r_state;

endmodule
